// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI request arbiter.
// Contents: arbiter FSM state encoding, default SPI word width, round-robin pointer helper.
package spi_arb_pkg;

  localparam int unsigned SPI_DATA_W = 12;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StBusy   = 2'd2
  } arb_state_e;

  // Pointer value after serving client idx: the client just above it, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Link between the arbiter and the shared SPI master.
// Signals:
//   spi_start  arbiter -> master  start request, held until the master drops cs
//   spi_din    arbiter -> master  word to shift out, stable for the whole transaction
//   spi_cs     master -> arbiter  chip select, low while a frame is in progress
//   spi_done   master -> arbiter  completion level, roughly one sclk period long
// Modports: master = the side that issues start (the arbiter), slave = the SPI master block.
interface spi_req_arbiter_if #(
  parameter int unsigned DATA_W = 12
);

  logic              spi_start;
  logic [DATA_W-1:0] spi_din;
  logic              spi_cs;
  logic              spi_done;

  modport master (
    output spi_start,
    output spi_din,
    input  spi_cs,
    input  spi_done
  );

  modport slave (
    input  spi_start,
    input  spi_din,
    output spi_cs,
    output spi_done
  );

endinterface

// File: rtl/spi_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req  in   NUM_REQ  request vector
//   ptr  in   IdxW     highest-priority position for this pick
//   win  out  NUM_REQ  one-hot winner (all zero when no request)
//   idx  out  IdxW     binary index of the winner
//   any  out  1        at least one request present
// The lowest request index at or after ptr wins, searching upward with wrap.
module spi_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IdxW-1:0]    idx,
  output logic               any
);

  int unsigned      pos;
  logic [IdxW-1:0]  cand;

  // Walk the offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    win  = '0;
    idx  = '0;
    pos  = 0;
    cand = '0;
    any  = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos  = (32'(ptr) + 32'(k)) % NUM_REQ;
      cand = IdxW'(pos);
      if (req[cand]) begin
        win       = '0;
        win[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ clients.
// Latches the winner's word, holds start until the master drops cs, then waits for the
// rising edge of done and pulses ack to the granted client.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   req         level request per client
//   req_data    client words, client i at [i*DATA_W +: DATA_W]
//   gnt         one-hot grant held for the whole transaction
//   ack         one-cycle completion pulse to the granted client
//   err         one-cycle timeout pulse, coincident with ack
//   busy        high while a transaction is being launched or is in flight
//   spi         master-side link to the SPI master (start/din/cs/done)
// Build option: define SPI_ARB_TIMEOUT_EN to abort a transaction that has not completed
// TIMEOUT_CYCLES cycles after its grant; undefined, err stays low and the arbiter waits forever.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = SPI_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      err,
  output logic                      busy,
  spi_req_arbiter_if.master         spi
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
    $error("spi_req_arbiter: NUM_REQ must be within 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("spi_req_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic              done_q;
  logic              done_rise;
  logic              timeout_hit;
  logic              xfer_end;

  logic [NUM_REQ-1:0] pick_win;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;

  spi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_picker (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign done_rise = spi.spi_done & ~done_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q;

  // Held at zero while idle, so it reads 0 in the first cycle after the grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == StIdle) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A done edge in the same cycle completes normally instead of timing out.
  assign timeout_hit = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) &&
                       !((state_q == StBusy) && done_rise);
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_end = ((state_q == StBusy) && done_rise) || timeout_hit;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    err_d   = 1'b0;
    start_d = start_q;
    din_d   = din_q;
    ptr_d   = ptr_q;
    widx_d  = widx_q;

    unique case (state_q)
      StIdle: begin
        // cs low means the master is still finishing a frame (e.g. one cut short by reset).
        if (pick_any && spi.spi_cs) begin
          gnt_d   = pick_win;
          din_d   = req_data[32'(pick_idx) * DATA_W +: DATA_W];
          start_d = 1'b1;
          widx_d  = pick_idx;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (!spi.spi_cs) begin
          start_d = 1'b0;
          state_d = StBusy;
        end
      end
      StBusy: begin
      end
      default: state_d = StIdle;
    endcase

    if (xfer_end) begin
      start_d = 1'b0;
      gnt_d   = '0;
      ack_d   = gnt_q;
      err_d   = timeout_hit;
      ptr_d   = IdxW'(rr_next(32'(widx_q), NUM_REQ));
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      din_q   <= '0;
      ptr_q   <= '0;
      widx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
      din_q   <= din_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      done_q  <= spi.spi_done;
    end
  end

  assign gnt           = gnt_q;
  assign ack           = ack_q;
  assign err           = err_q;
  assign busy          = (state_q != StIdle);
  assign spi.spi_start = start_q;
  assign spi.spi_din   = din_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
module tb_spi_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 12;
  localparam int unsigned TO = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            err;
  logic            busy;

  spi_req_arbiter_if #(.DATA_W(DW)) spi_if ();

  spi_req_arbiter #(
    .NUM_REQ        (N),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .spi      (spi_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  // Reference: lowest requesting index at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (((r >> j) & N'(1)) != '0) return j;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (((v >> i) & N'(1)) != '0) return i;
    end
    return -1;
  endfunction

  // Behavioural SPI master: no reset, accepts start only while idle (cs high).
  int           mst_lat  = 0;
  bit           mst_stub = 1'b0;
  logic [DW-1:0] mst_words[$];

  initial begin
    int lat;
    spi_if.spi_cs   = 1'b1;
    spi_if.spi_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!mst_stub && spi_if.spi_start === 1'b1 && spi_if.spi_cs) begin
        mst_words.push_back(spi_if.spi_din);
        spi_if.spi_cs = 1'b0;
        lat = (mst_lat != 0) ? mst_lat : int'($urandom_range(1, 6));
        repeat (lat) @(negedge clk);
        spi_if.spi_cs   = 1'b1;
        spi_if.spi_done = 1'b1;
        repeat (2) @(negedge clk);
        spi_if.spi_done = 1'b0;
      end
    end
  end

  // Event recorder plus protocol invariants (one-hot, held grant, stable din, ack matches gnt).
  int            gnt_log[$];
  int            ack_log[$];
  logic [DW-1:0] din_log[$];
  int            viol = 0;
  int            err_pulses = 0;
  logic [N-1:0]  prev_gnt = '0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (gnt != '0 && !$onehot(gnt)) viol++;
      if (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt) viol++;
      if (gnt != '0 && prev_gnt == '0) begin
        gnt_log.push_back(oh_idx(gnt));
        din_log.push_back(spi_if.spi_din);
      end else if (gnt != '0 && din_log.size() > 0 && spi_if.spi_din !== din_log[$]) begin
        viol++;
      end
      if (ack != '0) begin
        ack_log.push_back(oh_idx(ack));
        if (ack != prev_gnt || gnt != '0) viol++;
      end
      if (err === 1'b1) err_pulses++;
    end
    prev_gnt = gnt;
  end

  task automatic clear_logs();
    gnt_log.delete();
    ack_log.delete();
    din_log.delete();
    mst_words.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
  endtask

  // Waits for n ack pulses; drops every request on the n-th.
  task automatic wait_acks(input int n, input int budget, output bit ok);
    int seen;
    seen = 0;
    ok   = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        seen++;
        if (seen == n) begin
          req = '0;
          ok  = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b want=0", gnt); end
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got=%b want=0", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (spi_if.spi_start !== 1'b0) begin
      errors++; $display("FAIL reset_start got=%b want=0", spi_if.spi_start);
    end
    checks++;
    if (spi_if.spi_din !== '0) begin
      errors++; $display("FAIL reset_din got=%h want=0", spi_if.spi_din);
    end
    rst_n = 1'b1;
    model_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
    req_data[0 +: DW] = 12'hA5C;
    req = 4'b0001;
    wait_acks(1, 200, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL single_ack got=none want=ack[0]"); end
    checks++;
    if (mst_words.size() != 1 || mst_words[0] !== 12'hA5C) begin
      errors++; $display("FAIL single_word got_n=%0d want=1 word a5c", mst_words.size());
    end
    checks++;
    if (gnt_log.size() != 1 || gnt_log[0] != 0 || din_log[0] !== 12'hA5C) begin
      errors++; $display("FAIL single_gnt got_n=%0d want=1 grant to client 0", gnt_log.size());
    end
    checks++;
    if (ack_log.size() != 1 || ack_log[0] != 0) begin
      errors++; $display("FAIL single_ack_count got=%0d want=1", ack_log.size());
    end
    checks++;
    if (viol != 0 || err_pulses != 0) begin
      errors++; $display("FAIL single_protocol got viol=%0d err=%0d want=0", viol, err_pulses);
    end
    model_ptr = 1;
  endtask

  task automatic test_simultaneous();
    bit ok;
    int w;
    logic [DW-1:0] words[N];
    do_reset(2);
    clear_logs();
    for (int i = 0; i < N; i++) begin
      words[i] = DW'($urandom);
      req_data[i*DW +: DW] = words[i];
    end
    req = 4'b0101;
    wait_acks(2, 300, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL simul_acks got<2 want=2"); end
    for (int k = 0; k < 2; k++) begin
      w = rr_pick(4'b0101, model_ptr);
      model_ptr = (w + 1) % N;
      checks++;
      if (gnt_log.size() <= k || gnt_log[k] != w || mst_words.size() <= k ||
          mst_words[k] !== words[w]) begin
        errors++; $display("FAIL simul_order[%0d] want client %0d", k, w);
      end
    end
    checks++;
    if (viol != 0) begin errors++; $display("FAIL simul_onehot got viol=%0d want=0", viol); end
  endtask

  task automatic test_all_req();
    bit ok;
    int w;
    logic [DW-1:0] words[N];
    do_reset(2);
    clear_logs();
    for (int i = 0; i < N; i++) begin
      words[i] = DW'($urandom);
      req_data[i*DW +: DW] = words[i];
    end
    req = 4'b1111;
    wait_acks(8, 800, ok);
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL all_acks got<8 want=8"); end
    for (int k = 0; k < 8; k++) begin
      w = rr_pick(4'b1111, model_ptr);
      model_ptr = (w + 1) % N;
      checks++;
      if (gnt_log.size() <= k || gnt_log[k] != w || ack_log.size() <= k || ack_log[k] != w) begin
        errors++; $display("FAIL all_order[%0d] want client %0d", k, w);
      end
      checks++;
      if (mst_words.size() <= k || mst_words[k] !== words[w]) begin
        errors++; $display("FAIL all_word[%0d] want=%h", k, words[w]);
      end
    end
    checks++;
    if (ack_log.size() != 8 || viol != 0) begin
      errors++; $display("FAIL all_ack_count got=%0d want=8 viol=%0d", ack_log.size(), viol);
    end
  endtask

  task automatic test_req_drop();
    bit ok;
    bit seen_busy;
    int w0;
    int w1;
    do_reset(2);
    clear_logs();
    mst_lat = 6;
    req = 4'b1010;
    seen_busy = 1'b0;
    for (int c = 0; c < 50 && !seen_busy; c++) begin
      @(negedge clk);
      if (gnt == 4'b0010 && busy && !spi_if.spi_start && !spi_if.spi_cs) seen_busy = 1'b1;
    end
    checks++; if (!seen_busy) begin errors++; $display("FAIL drop_busy got=no want=busy on 1"); end
    req = 4'b1001;
    wait_acks(2, 300, ok);
    repeat (10) @(negedge clk);
    mst_lat = 0;
    w0 = rr_pick(4'b1010, model_ptr);
    model_ptr = (w0 + 1) % N;
    w1 = rr_pick(4'b1001, model_ptr);
    model_ptr = (w1 + 1) % N;
    checks++;
    if (!ok || ack_log.size() < 1 || ack_log[0] != w0) begin
      errors++; $display("FAIL drop_ack want ack to client %0d", w0);
    end
    checks++;
    if (gnt_log.size() != 2 || gnt_log[1] != w1) begin
      errors++; $display("FAIL drop_next got_n=%0d want client %0d", gnt_log.size(), w1);
    end
  endtask

  task automatic test_random();
    bit ok;
    int w;
    int exp_w[$];
    logic [DW-1:0] exp_word[$];
    logic [N-1:0] r;
    clear_logs();
    for (int it = 0; it < 12; it++) begin
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
      w = rr_pick(r, model_ptr);
      model_ptr = (w + 1) % N;
      exp_w.push_back(w);
      exp_word.push_back(req_data[w*DW +: DW]);
      req = r;
      repeat (2) @(negedge clk);
      // Words changed after the grant must not reach the master.
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
      wait_acks(1, 200, ok);
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (gnt_log.size() <= k || gnt_log[k] != exp_w[k] || mst_words.size() <= k ||
          mst_words[k] !== exp_word[k]) begin
        errors++; $display("FAIL rand[%0d] want client %0d word %h", k, exp_w[k], exp_word[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int bad;
    mst_lat = 25;
    req = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (busy && !spi_if.spi_start && !spi_if.spi_cs) seen = 1'b1;
    end
    rst_n = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (gnt !== '0 || ack !== '0 || err !== 1'b0 || busy !== 1'b0 ||
          spi_if.spi_start !== 1'b0 || spi_if.spi_din !== '0) bad++;
    end
    rst_n = 1'b1;
    model_ptr = 0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_outputs got bad=%0d want=0", bad); end
    clear_logs();
    bad = 0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (!spi_if.spi_cs && (gnt != '0 || spi_if.spi_start)) bad++;
      if (gnt != '0) seen = 1'b1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rstmid_early_gnt got bad=%0d want=0", bad); end
    checks++;
    if (!seen || gnt !== 4'b0001) begin
      errors++; $display("FAIL rstmid_regrant got=%b want=0001", gnt);
    end
    mst_lat = 3;
    wait_acks(1, 200, ok);
    repeat (10) @(negedge clk);
    mst_lat = 0;
    model_ptr = 1;
    checks++;
    if (!ok || ack_log.size() != 1 || ack_log[0] != 0) begin
      errors++; $display("FAIL rstmid_ack got_n=%0d want one ack[0]", ack_log.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    bit got;
    int cnt;
    int bad;
    repeat (10) @(negedge clk);
    mst_stub = 1'b1;
    do_reset(2);
    clear_logs();
    req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (gnt != '0) got = 1'b1;
    end
`ifdef SPI_ARB_TIMEOUT_EN
    cnt = 0;
    ok  = 1'b0;
    bad = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      cnt++;
      if (ack != '0) begin
        ok = 1'b1;
        req = '0;
        if (err !== 1'b1 || ack !== 4'b0001) bad++;
      end
    end
    checks++;
    if (!got || !ok || cnt != int'(TO)) begin
      errors++; $display("FAIL timeout_delay got=%0d want=%0d", cnt, TO);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_pulse got bad=%0d want err+ack[0]", bad); end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || gnt !== '0 || spi_if.spi_start !== 1'b0) begin
      errors++; $display("FAIL timeout_idle got err=%b busy=%b gnt=%b want 0", err, busy, gnt);
    end
    mst_stub = 1'b0;
`else
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (gnt !== 4'b0001 || spi_if.spi_start !== 1'b1 || ack !== '0 || err !== 1'b0) bad++;
    end
    checks++;
    if (!got || bad != 0) begin
      errors++; $display("FAIL wait_forever got bad=%0d want=0", bad);
    end
    mst_stub = 1'b0;
    mst_lat = 2;
    wait_acks(1, 100, ok);
    checks++;
    if (!ok || err_pulses != 0) begin
      errors++; $display("FAIL stall_recover got ok=%0d err=%0d want ack no err", ok, err_pulses);
    end
    mst_lat = 0;
`endif
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the run completed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_all_req();
    test_req_drop();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
